// File: rtl/demux_pkg.sv
// Shared sizing constants for the 32-lane word distributor.
package demux_pkg;
  localparam int NLANES = 32;
  localparam int SEL_W  = 5;
  localparam int CNT_W  = 8;
endpackage

// File: rtl/demux_lane.sv
// One output lane: data register plus "unconsumed" flag; write beats ack.
// Latency 1 from wr_en_i; the lane itself never stalls.
module demux_lane #(
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          ack_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o
);
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~ack_i;
    if (wr_en_i) begin
      data_d  = wr_data_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/demux_dist.sv
// Distributes one upstream word to a selected lane or to all lanes (broadcast).
// Latency 1; in_ready drops while any targeted lane still holds an unacked word.
module demux_dist
  import demux_pkg::*;
#(
  parameter int DW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  input  logic [DW-1:0]        in_data,
  output logic [NLANES*DW-1:0] out_data,
  output logic [NLANES-1:0]    out_valid,
  input  logic [NLANES-1:0]    out_ack,
  output logic [CNT_W-1:0]     accept_cnt
);
  logic [NLANES-1:0] lane_free;
  logic [NLANES-1:0] sel_onehot;
  logic [NLANES-1:0] lane_wr;
  logic              xfer;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A lane can take a word if it is empty or being consumed on this same edge.
  always_comb begin
    sel_onehot         = '0;
    sel_onehot[in_sel] = 1'b1;
    lane_free          = ~out_valid | out_ack;
    in_ready           = 1'b0;
    if (!rst) begin
      in_ready = in_bcast ? (&lane_free) : lane_free[in_sel];
    end
    xfer    = in_valid & in_ready;
    lane_wr = '0;
    if (xfer) begin
      lane_wr = in_bcast ? '1 : sel_onehot;
    end
    cnt_d = cnt_q + CNT_W'(xfer);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign accept_cnt = cnt_q;

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    demux_lane #(.DW(DW)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (lane_wr[i]),
      .wr_data_i (in_data),
      .ack_i     (out_ack[i]),
      .data_o    (out_data[i*DW +: DW]),
      .valid_o   (out_valid[i])
    );
  end
endmodule

// File: doc/demux_dist.md
DEMUX_DIST -- requirements
Module: demux_dist

Interface
REQ-001 Parameter DW, default 2, SHALL set the per-lane data width in bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL indicate that the upstream word is valid.
REQ-006 in_ready  output  1  SHALL indicate that demux_dist can accept the word this cycle.
REQ-007 in_sel  input  5  SHALL select the destination lane, 0..31.
REQ-008 in_bcast  input  1  SHALL, when 1, send the word to all 32 lanes and ignore in_sel.
REQ-009 in_data  input  DW  SHALL carry the word to distribute.
REQ-010 out_data  output  32*DW  SHALL hold the lane registers; lane i at bits [DW*i+DW-1 : DW*i].
REQ-011 out_valid  output  32  SHALL hold a per-lane flag meaning "lane i holds an unconsumed word".
REQ-012 out_ack  input  32  SHALL be the per-lane consume strobe; bit i consumes lane i.
REQ-013 accept_cnt  output  8  SHALL count accepted transfers, modulo 256.

Function
REQ-014 Transfer SHALL occur on a rising clk edge where in_valid=1 and in_ready=1; no other condition accepts a word.
REQ-015 Unicast: in_ready SHALL be combinational and equal ~out_valid[in_sel] | out_ack[in_sel].
REQ-016 Broadcast: in_ready SHALL equal 1 only when every lane i satisfies ~out_valid[i] | out_ack[i].
REQ-017 in_ready SHALL NOT depend on in_valid.
REQ-018 Unicast transfer SHALL write in_data to lane in_sel and set out_valid[in_sel]=1, visible the cycle after the accepting edge (latency 1).
REQ-019 All 32 in_sel values SHALL map one-to-one to lanes 0..31; no value is unmapped or aliased.
REQ-020 Broadcast transfer SHALL write in_data to all 32 lanes and set all out_valid bits on the same edge.
REQ-021 out_ack[i]=1 with out_valid[i]=1 SHALL clear out_valid[i] on that edge; out_data lane i SHALL keep its value.
REQ-022 out_ack[i]=1 with out_valid[i]=0 SHALL be ignored.
REQ-023 If a write and an ack hit lane i on the same edge, the write SHALL win: out_valid[i] stays 1 and lane i takes the new data.
REQ-024 Acks on lanes other than the written lane SHALL be applied independently on the same edge.
REQ-025 accept_cnt SHALL increment by 1 per transfer, unicast or broadcast, and wrap from 255 to 0.
REQ-026 While in_valid=1 and in_ready=0, upstream SHALL hold in_sel, in_bcast and in_data stable. demux_dist does not check this.

Reset
REQ-027 Asserting rst SHALL immediately clear out_valid to 0, out_data to 0 and accept_cnt to 0, independent of clk.
REQ-028 While rst=1, in_ready SHALL be 0 and no transfer or ack SHALL take effect.
REQ-029 After rst deasserts, the first rising edge SHALL accept a transfer if in_valid=1.
REQ-030 Reset in the middle of operation SHALL discard all held words without partial updates.

Structure
REQ-031 A shared package demux_pkg SHALL hold NLANES=32, SEL_W=5 and CNT_W=8.
REQ-032 The sub-module demux_lane SHALL implement one lane (data register and valid flag with write-over-ack priority); demux_dist instantiates it NLANES times.
REQ-033 The lane-select decode and the broadcast ready reduction SHALL live in demux_dist.

Verification
REQ-034 Bench SHALL cover this sweep: after reset, unicast in_sel=0..31 with in_data=sel[1:0], no acks -> lane i = i mod 4, out_valid=0xFFFFFFFF, accept_cnt=32.
REQ-035 Bench SHALL cover this stall: lane 13 valid and out_ack=0, then in_sel=13 with in_valid=1 -> in_ready=0 and lane 13 unchanged; assert out_ack[13] -> in_ready=1 and the new data lands with out_valid[13]=1.
REQ-036 Bench SHALL cover this broadcast: with lane 5 valid, broadcast in_data=2'b11 -> in_ready=0; ack lane 5 -> all lanes = 2'b11 one cycle after the accepting edge, out_valid all 1.
REQ-037 Bench SHALL cover simultaneous events: lane 12 valid, out_ack[12]=1 and out_ack[3]=1 (lane 3 valid), write to lane 12 on the same edge -> out_valid[12]=1 with new data, out_valid[3]=0.
REQ-038 Bench SHALL cover counter wrap: 256 transfers -> accept_cnt=0; the 257th transfer -> accept_cnt=1.
REQ-039 Bench SHALL cover reset mid-stream: assert rst between clock edges while lanes are valid -> out_valid=0, out_data=0 and accept_cnt=0 immediately, with in_ready=0 until release.
